bus_write_regfile: RTL and testbench

- Write-side counterpart of the 16-bit processor data bus. It decodes a 5-bit write code and loads the bus value into one destination register per cycle.
- It holds the architectural registers that feed the bus read mux: PC, IR, AR, DAR, TAC, R, AC, CI/CJ/CK, SI/SJ/SK, AA/AB/AD.
- It performs the control unit's increment and clear micro-ops, and drives the data-memory write strobe.
- It sits between the control unit and the datapath of the matrix-multiplication processor.

---
 rtl/bus_pkg.sv | 29 ++
 rtl/bus_reg_cell.sv | 29 ++
 rtl/bus_write_regfile.sv | 150 +++++++++++++++
 tb/tb_bus_write_regfile.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared codes and sizes for the processor data bus (read mux and write-side register file).
package bus_pkg;
  localparam int DW_DEF = 16;
  localparam int AW_DEF = 8;

  // Write codes; read codes use the same values.
  localparam logic [4:0] WR_NONE = 5'd0,  WR_AR  = 5'd1,  WR_DM  = 5'd2,  WR_IR  = 5'd3;
  localparam logic [4:0] WR_PC   = 5'd4,  WR_TAC = 5'd5,  WR_R   = 5'd6,  WR_CI  = 5'd7;
  localparam logic [4:0] WR_CJ   = 5'd8,  WR_CK  = 5'd9,  WR_AA  = 5'd10, WR_AB  = 5'd11;
  localparam logic [4:0] WR_AD   = 5'd12, WR_SI  = 5'd13, WR_SJ  = 5'd14, WR_SK  = 5'd15;
  localparam logic [4:0] WR_AC   = 5'd16, WR_DAR = 5'd17, WR_LAST = 5'd17;

  localparam logic [4:0] RD_AR = WR_AR, RD_DM = WR_DM, RD_IR = WR_IR, RD_PC = WR_PC;
  localparam logic [4:0] RD_TAC = WR_TAC, RD_R = WR_R, RD_CI = WR_CI, RD_CJ = WR_CJ;
  localparam logic [4:0] RD_CK = WR_CK, RD_AA = WR_AA, RD_AB = WR_AB, RD_AD = WR_AD;
  localparam logic [4:0] RD_SI = WR_SI, RD_SJ = WR_SJ, RD_SK = WR_SK, RD_AC = WR_AC;
  localparam logic [4:0] RD_DAR = WR_DAR;

  localparam logic [2:0] INC_NONE = 3'd0, INC_PC = 3'd1, INC_CI = 3'd2, INC_CJ = 3'd3;
  localparam logic [2:0] INC_CK = 3'd4, INC_AR = 3'd5, INC_DAR = 3'd6, INC_AC = 3'd7;

  localparam logic [2:0] CLR_NONE = 3'd0, CLR_CI = 3'd1, CLR_CJ = 3'd2, CLR_CK = 3'd3;
  localparam logic [2:0] CLR_AC = 3'd4, CLR_R = 3'd5, CLR_TAC = 3'd6, CLR_CIJK = 3'd7;

  // Slot indices of the narrow and wide register banks.
  localparam int N_PC = 0, N_IR = 1, N_AR = 2, N_DAR = 3, N_CI = 4, N_CJ = 5, N_CK = 6;
  localparam int N_SI = 7, N_SJ = 8, N_SK = 9, N_AA = 10, N_AB = 11, N_AD = 12, NN = 13;
  localparam int W_TAC = 0, W_R = 1, W_AC = 2, NW = 3;
endpackage

// File: rtl/bus_reg_cell.sv
// One architectural register: load beats clear beats increment; flags any overlap.
module bus_reg_cell #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         ld,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] din,
  output logic [W-1:0] q,
  output logic         conflict
);
  logic [W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (ld)       val_d = din;
    else if (clr) val_d = '0;
    else if (inc) val_d = val_q + W'(1);
  end

  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;

  assign q        = val_q;
  assign conflict = (ld & clr) | (ld & inc) | (clr & inc);
endmodule

// File: rtl/bus_write_regfile.sv
// Write side of the data bus: decodes write/inc/clr codes onto per-register cells,
// drives the data-memory strobe and keeps the z, conflict and illegal flags.
module bus_write_regfile
  import bus_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [4:0]    write,
  input  logic [DW-1:0] busin,
  input  logic [2:0]    inc,
  input  logic [2:0]    clr,
  output logic [AW-1:0] PC, IR, AR, DAR, CI, CJ, CK, SI, SJ, SK, AA, AB, AD,
  output logic [DW-1:0] TAC, R, AC,
  output logic          dm_we,
  output logic [AW-1:0] dm_addr,
  output logic [DW-1:0] dm_wdata,
  output logic          z,
  output logic          conflict,
  output logic          illegal
);
  logic [NN-1:0]         n_ld, n_clr, n_inc, n_cf;
  logic [NN-1:0][AW-1:0] n_q;
  logic [NW-1:0]         w_ld, w_clr, w_inc, w_cf;
  logic [NW-1:0][DW-1:0] w_q;

  always_comb begin
    n_ld = '0;
    w_ld = '0;
    case (write)
      WR_AR:   n_ld[N_AR]  = 1'b1;
      WR_IR:   n_ld[N_IR]  = 1'b1;
      WR_PC:   n_ld[N_PC]  = 1'b1;
      WR_TAC:  w_ld[W_TAC] = 1'b1;
      WR_R:    w_ld[W_R]   = 1'b1;
      WR_CI:   n_ld[N_CI]  = 1'b1;
      WR_CJ:   n_ld[N_CJ]  = 1'b1;
      WR_CK:   n_ld[N_CK]  = 1'b1;
      WR_AA:   n_ld[N_AA]  = 1'b1;
      WR_AB:   n_ld[N_AB]  = 1'b1;
      WR_AD:   n_ld[N_AD]  = 1'b1;
      WR_SI:   n_ld[N_SI]  = 1'b1;
      WR_SJ:   n_ld[N_SJ]  = 1'b1;
      WR_SK:   n_ld[N_SK]  = 1'b1;
      WR_AC:   w_ld[W_AC]  = 1'b1;
      WR_DAR:  n_ld[N_DAR] = 1'b1;
      default: ;
    endcase

    n_inc = '0;
    w_inc = '0;
    case (inc)
      INC_PC:  n_inc[N_PC]  = 1'b1;
      INC_CI:  n_inc[N_CI]  = 1'b1;
      INC_CJ:  n_inc[N_CJ]  = 1'b1;
      INC_CK:  n_inc[N_CK]  = 1'b1;
      INC_AR:  n_inc[N_AR]  = 1'b1;
      INC_DAR: n_inc[N_DAR] = 1'b1;
      INC_AC:  w_inc[W_AC]  = 1'b1;
      default: ;
    endcase

    n_clr = '0;
    w_clr = '0;
    case (clr)
      CLR_CI:   n_clr[N_CI]  = 1'b1;
      CLR_CJ:   n_clr[N_CJ]  = 1'b1;
      CLR_CK:   n_clr[N_CK]  = 1'b1;
      CLR_AC:   w_clr[W_AC]  = 1'b1;
      CLR_R:    w_clr[W_R]   = 1'b1;
      CLR_TAC:  w_clr[W_TAC] = 1'b1;
      CLR_CIJK: begin
        n_clr[N_CI] = 1'b1;
        n_clr[N_CJ] = 1'b1;
        n_clr[N_CK] = 1'b1;
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < NN; i++) begin : g_narrow
    bus_reg_cell #(.W(AW)) u_cell (
      .clock(clock), .rst_n(rst_n), .ld(n_ld[i]), .clr(n_clr[i]), .inc(n_inc[i]),
      .din(busin[AW-1:0]), .q(n_q[i]), .conflict(n_cf[i])
    );
  end

  for (genvar i = 0; i < NW; i++) begin : g_wide
    bus_reg_cell #(.W(DW)) u_cell (
      .clock(clock), .rst_n(rst_n), .ld(w_ld[i]), .clr(w_clr[i]), .inc(w_inc[i]),
      .din(busin), .q(w_q[i]), .conflict(w_cf[i])
    );
  end

  logic          dm_we_q, dm_we_d, z_q, z_d, conflict_q, conflict_d, illegal_q, illegal_d;
  logic [DW-1:0] dm_wdata_q, dm_wdata_d;

  always_comb begin
    dm_we_d    = (write == WR_DM);
    dm_wdata_d = dm_we_d ? busin : dm_wdata_q;
    conflict_d = conflict_q | (|n_cf) | (|w_cf);
    illegal_d  = illegal_q | (write > WR_LAST);
    // Zero test of AC's next value, following the cell's priority order.
    if (w_ld[W_AC])       z_d = (busin == '0);
    else if (w_clr[W_AC]) z_d = 1'b1;
    else if (w_inc[W_AC]) z_d = &w_q[W_AC];
    else                  z_d = (w_q[W_AC] == '0);
  end

  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      dm_we_q    <= 1'b0;
      dm_wdata_q <= '0;
      z_q        <= 1'b1;
      conflict_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      dm_we_q    <= dm_we_d;
      dm_wdata_q <= dm_wdata_d;
      z_q        <= z_d;
      conflict_q <= conflict_d;
      illegal_q  <= illegal_d;
    end

  assign PC  = n_q[N_PC];
  assign IR  = n_q[N_IR];
  assign AR  = n_q[N_AR];
  assign DAR = n_q[N_DAR];
  assign CI  = n_q[N_CI];
  assign CJ  = n_q[N_CJ];
  assign CK  = n_q[N_CK];
  assign SI  = n_q[N_SI];
  assign SJ  = n_q[N_SJ];
  assign SK  = n_q[N_SK];
  assign AA  = n_q[N_AA];
  assign AB  = n_q[N_AB];
  assign AD  = n_q[N_AD];
  assign TAC = w_q[W_TAC];
  assign R   = w_q[W_R];
  assign AC  = w_q[W_AC];

  assign dm_we    = dm_we_q;
  assign dm_addr  = n_q[N_DAR];
  assign dm_wdata = dm_wdata_q;
  assign z        = z_q;
  assign conflict = conflict_q;
  assign illegal  = illegal_q;
endmodule

// File: tb/tb_bus_write_regfile.sv
// Bench for bus_write_regfile: hand vectors, reset corner cases, random ops vs a register-map model.
module tb_bus_write_regfile;
  logic        clock = 1'b0;
  logic        rst_n;
  logic [4:0]  write;
  logic [15:0] busin;
  logic [2:0]  inc, clr;
  logic [7:0]  PC, IR, AR, DAR, CI, CJ, CK, SI, SJ, SK, AA, AB, AD, dm_addr;
  logic [15:0] TAC, R, AC, dm_wdata;
  logic        dm_we, z, conflict, illegal;

  bus_write_regfile dut (
    .clock(clock), .rst_n(rst_n), .write(write), .busin(busin), .inc(inc), .clr(clr),
    .PC(PC), .IR(IR), .AR(AR), .DAR(DAR), .CI(CI), .CJ(CJ), .CK(CK), .SI(SI), .SJ(SJ),
    .SK(SK), .AA(AA), .AB(AB), .AD(AD), .TAC(TAC), .R(R), .AC(AC), .dm_we(dm_we),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .z(z), .conflict(conflict), .illegal(illegal)
  );

  always #5 clock = ~clock;

  // Output ids: 0..15 registers (PC IR AR DAR CI CJ CK SI SJ SK AA AB AD TAC R AC),
  // 16 dm_we, 17 dm_addr, 18 dm_wdata, 19 z, 20 conflict, 21 illegal.
  string onames[22] = '{"PC", "IR", "AR", "DAR", "CI", "CJ", "CK", "SI", "SJ", "SK", "AA",
                        "AB", "AD", "TAC", "R", "AC", "dm_we", "dm_addr", "dm_wdata", "z",
                        "conflict", "illegal"};
  int wr_tgt[32];
  int inc_tgt[8];

  logic [15:0] m[16];
  logic        m_we, m_z, m_conf, m_ill;
  logic [15:0] m_wdata;
  int checks = 0, errors = 0;

  function automatic logic [15:0] get_out(int id);
    case (id)
      0:  return {8'h0, PC};   1:  return {8'h0, IR};   2:  return {8'h0, AR};
      3:  return {8'h0, DAR};  4:  return {8'h0, CI};   5:  return {8'h0, CJ};
      6:  return {8'h0, CK};   7:  return {8'h0, SI};   8:  return {8'h0, SJ};
      9:  return {8'h0, SK};   10: return {8'h0, AA};   11: return {8'h0, AB};
      12: return {8'h0, AD};   13: return TAC;          14: return R;
      15: return AC;           16: return {15'h0, dm_we};
      17: return {8'h0, dm_addr};
      18: return dm_wdata;     19: return {15'h0, z};
      20: return {15'h0, conflict};
      default: return {15'h0, illegal};
    endcase
  endfunction

  function automatic logic [15:0] model_out(int id);
    case (id)
      16: return {15'h0, m_we};
      17: return m[3];
      18: return m_wdata;
      19: return {15'h0, m_z};
      20: return {15'h0, m_conf};
      21: return {15'h0, m_ill};
      default: return m[id];
    endcase
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(string tag);
    for (int id = 0; id < 22; id++) chk({tag, ".", onames[id]}, get_out(id), model_out(id));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m[i] = '0;
    m_we = 0; m_wdata = '0; m_z = 1; m_conf = 0; m_ill = 0;
  endtask

  function automatic bit clr_hits(logic [2:0] c, int id);
    case (c)
      3'd1: return id == 4;
      3'd2: return id == 5;
      3'd3: return id == 6;
      3'd4: return id == 15;
      3'd5: return id == 14;
      3'd6: return id == 13;
      3'd7: return id >= 4 && id <= 6;
      default: return 0;
    endcase
  endfunction

  // One clock of the architectural rules: per register, count the ops aiming at it.
  task automatic model_step(logic [4:0] w, logic [15:0] b, logic [2:0] i, logic [2:0] c);
    logic [15:0] nx[16];
    for (int id = 0; id < 16; id++) begin
      int mask = (id >= 13) ? 16'hFFFF : 16'h00FF;
      bit hw = (wr_tgt[w] == id);
      bit hc = clr_hits(c, id);
      bit hi = (inc_tgt[i] == id);
      if (int'(hw) + int'(hc) + int'(hi) > 1) m_conf = 1;
      if (hw)      nx[id] = b & mask[15:0];
      else if (hc) nx[id] = 0;
      else if (hi) nx[id] = 16'((int'(m[id]) + 1) & mask);
      else         nx[id] = m[id];
    end
    m = nx;
    m_z  = (m[15] == 0);
    m_we = (w == 2);
    if (w == 2) m_wdata = b;
    if (w >= 18) m_ill = 1;
  endtask

  task automatic step(logic [4:0] w, logic [15:0] b, logic [2:0] i, logic [2:0] c, string tag);
    write = w; busin = b; inc = i; clr = c;
    model_step(w, b, i, c);
    @(posedge clock);
    #1;
    check_all(tag);
  endtask

  typedef struct {
    logic [4:0]  wr;
    logic [15:0] bus;
    logic [2:0]  inc, clr;
    int          id1;
    logic [15:0] e1;
    int          id2;
    logic [15:0] e2;
  } vec_t;
  vec_t tv[17];

  initial begin
    for (int k = 0; k < 32; k++) wr_tgt[k] = -1;
    wr_tgt[1] = 2;  wr_tgt[3] = 1;   wr_tgt[4] = 0;   wr_tgt[5] = 13;  wr_tgt[6] = 14;
    wr_tgt[7] = 4;  wr_tgt[8] = 5;   wr_tgt[9] = 6;   wr_tgt[10] = 10; wr_tgt[11] = 11;
    wr_tgt[12] = 12; wr_tgt[13] = 7; wr_tgt[14] = 8;  wr_tgt[15] = 9;  wr_tgt[16] = 15;
    wr_tgt[17] = 3;
    inc_tgt = '{-1, 0, 4, 5, 6, 2, 3, 15};

    tv[0]  = '{5'd16, 16'hABCD, 3'd0, 3'd0, 15, 16'hABCD, 19, 16'h0};
    tv[1]  = '{5'd7,  16'hBE05, 3'd0, 3'd0, 4,  16'h0005, 15, 16'hABCD};
    tv[2]  = '{5'd17, 16'h0042, 3'd0, 3'd0, 3,  16'h0042, 16, 16'h0};
    tv[3]  = '{5'd2,  16'h7777, 3'd0, 3'd0, 16, 16'h1,    18, 16'h7777};
    tv[4]  = '{5'd0,  16'h0000, 3'd0, 3'd0, 17, 16'h0042, 16, 16'h0};
    tv[5]  = '{5'd4,  16'h00FF, 3'd0, 3'd0, 0,  16'h00FF, 1,  16'h0};
    tv[6]  = '{5'd0,  16'h0000, 3'd1, 3'd0, 0,  16'h0000, 20, 16'h0};
    tv[7]  = '{5'd16, 16'hFFFF, 3'd0, 3'd0, 15, 16'hFFFF, 19, 16'h0};
    tv[8]  = '{5'd0,  16'h0000, 3'd7, 3'd0, 15, 16'h0000, 19, 16'h1};
    tv[9]  = '{5'd7,  16'h0011, 3'd0, 3'd0, 4,  16'h0011, 20, 16'h0};
    tv[10] = '{5'd9,  16'h0033, 3'd0, 3'd0, 6,  16'h0033, 20, 16'h0};
    tv[11] = '{5'd8,  16'h0009, 3'd3, 3'd7, 5,  16'h0009, 20, 16'h1};
    tv[12] = '{5'd0,  16'h0000, 3'd0, 3'd0, 4,  16'h0000, 6,  16'h0};
    tv[13] = '{5'd5,  16'h1234, 3'd1, 3'd4, 13, 16'h1234, 0,  16'h0001};
    tv[14] = '{5'd0,  16'h0000, 3'd0, 3'd0, 20, 16'h1,    21, 16'h0};
    tv[15] = '{5'd25, 16'hFFFF, 3'd0, 3'd0, 21, 16'h1,    15, 16'h0};
    tv[16] = '{5'd0,  16'h0000, 3'd0, 3'd0, 21, 16'h1,    13, 16'h1234};

    rst_n = 0; write = 0; busin = 0; inc = 0; clr = 0;
    model_reset();
    #12;
    check_all("reset");
    rst_n = 1;

    for (int k = 0; k < 17; k++) begin
      step(tv[k].wr, tv[k].bus, tv[k].inc, tv[k].clr, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d.%s", k, onames[tv[k].id1]), get_out(tv[k].id1), tv[k].e1);
      chk($sformatf("vec%0d.%s", k, onames[tv[k].id2]), get_out(tv[k].id2), tv[k].e2);
    end

    // Mid-run reset with a dm_we pulse in flight and AC nonzero.
    step(5'd16, 16'h1234, 3'd0, 3'd0, "pre_rst");
    step(5'd2,  16'h5555, 3'd0, 3'd0, "pre_rst_dm");
    chk("pre_rst.AC", AC, 16'h1234);
    #2;
    rst_n = 0;
    write = 5'd16; busin = 16'hFFFF; inc = 3'd7; clr = 3'd0;
    model_reset();
    #1;
    check_all("rst_async");
    chk("rst_async.dm_we", {15'h0, dm_we}, 16'h0);
    chk("rst_async.z", {15'h0, z}, 16'h1);
    @(posedge clock);
    #1;
    check_all("rst_hold");
    rst_n = 1;

    for (int k = 0; k < 600; k++) begin
      logic [4:0] w;
      if (k == 300) begin
        rst_n = 0; #1; model_reset(); rst_n = 1;
      end
      w = ($urandom_range(0, 19) == 0) ? 5'($urandom_range(18, 31)) : 5'($urandom_range(0, 17));
      step(w, 16'($urandom), 3'($urandom_range(0, 7)),
           ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'd0, $sformatf("rnd%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
